// File: rtl/regbank_dump_pkg.sv
// Shared constants for the register-bank dump: FSM state encoding and frame header byte.
package regbank_dump_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_HALT_WAIT = 3'd1,
      S_HEADER    = 3'd2,
      S_LOAD      = 3'd3,
      S_SEND      = 3'd4,
      S_CSUM      = 3'd5,
      S_DONE      = 3'd6
   } state_t;

   localparam logic [7:0] DUMP_HEADER = 8'hA5;

endpackage

// File: rtl/regbank_dump_byte_ser.sv
// 32-bit word to four big-endian bytes over valid/ready; byte counter moves only on handshake.
module dump_byte_ser (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] word_in,
   input  logic        active,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic        last,
   output logic        fire
);

   logic [31:0] word;
   logic [1:0]  cnt;

   assign out_valid = active;
   assign fire      = active && out_ready;
   assign last      = (cnt == 2'd3);

   // Counter wraps 3 -> 0 naturally, leaving it ready for the next word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word <= '0;
         cnt  <= '0;
      end else if (load) begin
         word <= word_in;
         cnt  <= '0;
      end else if (fire) begin
         cnt <= cnt + 2'd1;
      end
   end

   always_comb begin
      out_data = 8'h00;
      case (cnt)
         2'd0: out_data = word[31:24];
         2'd1: out_data = word[23:16];
         2'd2: out_data = word[15:8];
         2'd3: out_data = word[7:0];
         default: out_data = 8'h00;
      endcase
   end

endmodule

// File: rtl/regbank_dump.sv
// Halts the CPU, reads FIRST_REG..LAST_REG through the debug read port and streams
// header, big-endian register bytes and an XOR checksum as a valid/ready byte frame.
module regbank_dump
   import regbank_dump_pkg::*;
#(
   parameter logic [3:0] FIRST_REG = 4'd1,
   parameter logic [3:0] LAST_REG  = 4'd15,
   parameter logic [7:0] HEADER    = DUMP_HEADER
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        halt_req,
   input  logic        halt_ack,
   output logic [3:0]  rd_addr,
   input  logic [31:0] rd_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        done
);

   state_t     state, state_nxt;
   logic [3:0] idx;
   logic [7:0] csum;
   logic [7:0] ser_data;
   logic       ser_valid, ser_last, ser_fire;

   dump_byte_ser u_ser (
      .clk       (clk),
      .reset     (reset),
      .load      (state == S_LOAD),
      .word_in   (rd_data),
      .active    (state == S_SEND),
      .out_ready (tx_ready),
      .out_valid (ser_valid),
      .out_data  (ser_data),
      .last      (ser_last),
      .fire      (ser_fire)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (start)    state_nxt = S_HALT_WAIT;
         S_HALT_WAIT: if (halt_ack) state_nxt = S_HEADER;
         S_HEADER:    if (tx_ready) state_nxt = S_LOAD;
         S_LOAD:      state_nxt = S_SEND;
         S_SEND:      if (ser_fire && ser_last)
                         state_nxt = (idx == LAST_REG) ? S_CSUM : S_LOAD;
         S_CSUM:      if (tx_ready) state_nxt = S_DONE;
         S_DONE:      state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   // rd_addr is loaded with the index the coming LOAD cycle will read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx     <= '0;
         csum    <= '0;
         rd_addr <= '0;
      end else begin
         if (state == S_HALT_WAIT && halt_ack) begin
            idx  <= FIRST_REG;
            csum <= '0;
         end
         if (ser_fire) begin
            csum <= csum ^ ser_data;
            if (ser_last && idx != LAST_REG) idx <= idx + 4'd1;
         end
         if (state_nxt == S_LOAD && state != S_LOAD)
            rd_addr <= (state == S_SEND) ? idx + 4'd1 : idx;
         else if (state == S_DONE)
            rd_addr <= '0;
      end
   end

   assign busy     = (state != S_IDLE);
   assign done     = (state == S_DONE);
   assign halt_req = busy && !done;
   assign tx_valid = (state == S_HEADER) || ser_valid || (state == S_CSUM);

   always_comb begin
      tx_data = 8'h00;
      case (state)
         S_HEADER: tx_data = HEADER;
         S_SEND:   tx_data = ser_data;
         S_CSUM:   tx_data = csum;
         default:  tx_data = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_regbank_dump.sv
// Bench for regbank_dump: table-driven register patterns, random contents with random
// backpressure against a frame model, plus late-ack, start-while-busy and reset-abort sequences.
module tb_regbank_dump;

   localparam int FIRST = 1;
   localparam int LAST  = 15;
   localparam int FLEN  = 2 + 4 * (LAST - FIRST + 1);

   typedef struct {
      int          mode;     // 0: rN=val*N, 1: r1=val, 2: all=val, 3: r15=val
      logic [31:0] val;
      bit          rnd;
      logic [7:0]  exp_csum;
      int          exp_len;
   } vec_t;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        start    = 1'b0;
   logic        halt_ack = 1'b0;
   logic        tx_ready = 1'b1;
   logic        halt_req, tx_valid, busy, done;
   logic [3:0]  rd_addr;
   logic [31:0] rd_data;
   logic [7:0]  tx_data;

   logic [31:0] regs [16];
   bit          ready_rand = 1'b0;
   bit          ack_hold   = 1'b0;
   int          n_checks   = 0;
   int          n_errors   = 0;
   logic [7:0]  got [$];
   logic [7:0]  exp_q [$];
   int          done_total = 0, busy_total = 0, stall_total = 0, stall_bad = 0;
   int          hold_total = 0, hold_bad = 0;
   bit          stall_pend = 1'b0;
   logic [7:0]  stall_byte = 8'h00;

   always #5 clk = ~clk;

   assign rd_data = (rd_addr == 4'd0) ? 32'h0 : regs[rd_addr];

   regbank_dump dut (
      .clk      (clk),
      .reset    (rst_n),
      .start    (start),
      .halt_req (halt_req),
      .halt_ack (halt_ack),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy),
      .done     (done)
   );

   // CPU model: acknowledges one cycle after the request unless held off.
   always @(posedge clk) halt_ack <= halt_req && !ack_hold;

   always @(posedge clk) begin
      #1;
      tx_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         stall_pend = 1'b0;
      end else begin
         if (stall_pend) begin
            stall_total++;
            if (!tx_valid || tx_data !== stall_byte) stall_bad++;
         end
         if (tx_valid && tx_ready) got.push_back(tx_data);
         if (done) done_total++;
         if (busy) busy_total++;
         if (ack_hold && halt_req) begin
            hold_total++;
            if (tx_valid || rd_addr != 4'd0) hold_bad++;
         end
         stall_pend = tx_valid && !tx_ready;
         stall_byte = tx_data;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int c = 0;
      while (busy && c < max) begin
         @(posedge clk); #1;
         c++;
      end
      if (busy) chk("idle_timeout", 32'd1, 32'd0);
   endtask

   // Reference frame straight from the format: header, each register MSB first, XOR of data bytes.
   task automatic build_expected();
      logic [7:0] cs = 8'h00;
      logic [7:0] b;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      for (int r = FIRST; r <= LAST; r++)
         for (int k = 3; k >= 0; k--) begin
            b = regs[r][8*k +: 8];
            exp_q.push_back(b);
            cs ^= b;
         end
      exp_q.push_back(cs);
   endtask

   task automatic preload(input int mode, input logic [31:0] val);
      for (int r = 0; r < 16; r++) begin
         case (mode)
            0:       regs[r] = val * r;
            1:       regs[r] = (r == 1)  ? val : 32'h0;
            2:       regs[r] = val;
            3:       regs[r] = (r == 15) ? val : 32'h0;
            default: regs[r] = $urandom;
         endcase
      end
   endtask

   task automatic check_frame(input int base, input string nm);
      int n   = int'(got.size()) - base;
      int bad = 0;
      chk({nm, "_len"}, n, FLEN);
      for (int i = 0; i < n && i < exp_q.size(); i++)
         if (got[base + i] !== exp_q[i]) bad++;
      chk({nm, "_byte_mismatches"}, bad, 0);
   endtask

   initial begin
      vec_t vecs [6];
      int   base, d0, b0, s0, st0, h0, hb0, c;
      logic [7:0] last_b;

      vecs[0] = '{0, 32'h0101_0101, 1'b0, 8'h00, 62};
      vecs[1] = '{1, 32'hDEAD_BEEF, 1'b0, 8'h22, 62};
      vecs[2] = '{2, 32'hFFFF_FFFF, 1'b0, 8'h00, 62};
      vecs[3] = '{3, 32'h1234_5678, 1'b0, 8'h08, 62};
      vecs[4] = '{0, 32'h0101_0101, 1'b1, 8'h00, 62};
      vecs[5] = '{1, 32'h0000_00FF, 1'b1, 8'hFF, 62};

      preload(0, 32'h0101_0101);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_halt_req", halt_req, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_busy",     busy,     0);
      chk("rst_done",     done,     0);
      chk("rst_tx_data",  tx_data,  0);
      chk("rst_rd_addr",  rd_addr,  0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         preload(vecs[i].mode, vecs[i].val);
         build_expected();
         ready_rand = vecs[i].rnd;
         base = got.size(); d0 = done_total; b0 = busy_total; s0 = stall_bad; st0 = stall_total;
         pulse_start();
         wait_idle(3000);
         repeat (2) @(posedge clk);
         #1;
         check_frame(base, $sformatf("vec%0d", i));
         last_b = (int'(got.size()) > base) ? got[got.size() - 1] : 8'hxx;
         chk($sformatf("vec%0d_csum", i), last_b, vecs[i].exp_csum);
         chk($sformatf("vec%0d_len_tbl", i), int'(got.size()) - base, vecs[i].exp_len);
         chk($sformatf("vec%0d_done_pulses", i), done_total - d0, 1);
         if (!vecs[i].rnd) chk($sformatf("vec%0d_busy_cycles", i), busy_total - b0, 80);
         else              chk($sformatf("vec%0d_stalls_seen", i), 32'(stall_total > st0), 1);
         chk($sformatf("vec%0d_stall_hold", i), stall_bad - s0, 0);
      end

      for (int k = 0; k < 3; k++) begin
         preload(9, 32'h0);
         build_expected();
         ready_rand = 1'b1;
         base = got.size(); d0 = done_total; s0 = stall_bad;
         pulse_start();
         wait_idle(3000);
         repeat (2) @(posedge clk);
         #1;
         check_frame(base, $sformatf("rand%0d", k));
         chk($sformatf("rand%0d_done", k), done_total - d0, 1);
         chk($sformatf("rand%0d_stall_hold", k), stall_bad - s0, 0);
      end
      ready_rand = 1'b0;

      // Late acknowledge: nothing may be streamed or addressed until the CPU answers.
      preload(0, 32'h0101_0101);
      build_expected();
      ack_hold = 1'b1;
      base = got.size(); h0 = hold_total; hb0 = hold_bad;
      pulse_start();
      repeat (20) @(posedge clk);
      #1;
      chk("late_halt_req", halt_req, 1);
      chk("late_tx_valid", tx_valid, 0);
      chk("late_hold_bad", hold_bad - hb0, 0);
      chk("late_hold_seen", 32'(hold_total - h0 >= 19), 1);
      ack_hold = 1'b0;
      c = 0;
      while (!halt_ack && c < 5) begin
         @(posedge clk); #1;
         c++;
      end
      chk("late_ack_seen", halt_ack, 1);
      @(posedge clk); #1;
      chk("late_hdr_valid", tx_valid, 1);
      chk("late_hdr_data", tx_data, 8'hA5);
      wait_idle(3000);
      check_frame(base, "late");

      // start mid-frame and during DONE must be dropped.
      base = got.size(); d0 = done_total;
      pulse_start();
      repeat (30) @(posedge clk);
      #1;
      pulse_start();
      c = 0;
      while (!done && c < 3000) begin
         @(posedge clk); #1;
         c++;
      end
      chk("busy_done_seen", done, 1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("busy_restart_idle", busy, 0);
      check_frame(base, "busy");
      chk("busy_done_pulses", done_total - d0, 1);

      // Reset during byte 3 of r7 aborts immediately; a fresh start gives a full frame.
      base = got.size(); d0 = done_total;
      pulse_start();
      c = 0;
      while (int'(got.size()) - base < 27 && c < 3000) begin
         @(posedge clk); #1;
         c++;
      end
      chk("abort_rd_addr", rd_addr, 4'd7);
      rst_n = 1'b0;
      #1;
      chk("abort_halt_req", halt_req, 0);
      chk("abort_tx_valid", tx_valid, 0);
      chk("abort_busy",     busy,     0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("abort_no_more_bytes", int'(got.size()) - base, 27);
      chk("abort_no_done", done_total - d0, 0);
      base = got.size(); d0 = done_total;
      pulse_start();
      wait_idle(3000);
      repeat (2) @(posedge clk);
      #1;
      check_frame(base, "after_abort");
      chk("after_abort_done", done_total - d0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/regbank_dump.md
Name: regbank_dump

Overview:
- Debug reader for the CPU register bank.
- On a start pulse it requests a CPU halt and waits for acknowledge. It then reads r1..r15 one at a time through a dedicated read address/data port, which the CPU muxes onto a regbank read port while halted.
- It streams the values as a byte frame over a valid/ready interface, e.g. into the UART transmitter.
- Frame format: header byte, 60 data bytes (big-endian words), XOR checksum byte.

Parameters:
- FIRST_REG, 1, first register index dumped (4-bit).
- LAST_REG, 15, last register index dumped (4-bit, >= FIRST_REG).
- HEADER, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to dump; ignored while busy.
- halt_req  out  1  request CPU to freeze and hand over the read port.
- halt_ack  in  1  CPU is frozen and rd_addr is routed to the regbank.
- rd_addr  out  4  register read address.
- rd_data  in  32  combinational read data for rd_addr (r0 reads 0).
- tx_data  out  8  stream byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts byte when tx_valid && tx_ready.
- busy  out  1  high from start accept until done.
- done  out  1  one-cycle pulse after checksum byte is accepted.

Behaviour:
- Reset (asynchronous, active-low):
  - State = IDLE.
  - halt_req, tx_valid, busy and done are 0.
  - tx_data = 0, rd_addr = 0.
  - Internal register index, byte counter, word register and checksum are 0.
- Reset asserted mid-frame aborts immediately. halt_req drops with reset, with no done pulse and no further bytes.
- States:
  - IDLE -> HALT_WAIT on start.
  - HALT_WAIT -> HEADER on halt_ack.
  - HEADER -> LOAD on handshake.
  - LOAD -> SEND (always, 1 cycle).
  - SEND -> SEND on handshake while bytes remain.
  - SEND -> LOAD after the 4th byte handshake if idx != LAST_REG.
  - SEND -> CSUM after the 4th byte handshake if idx == LAST_REG.
  - CSUM -> DONE on handshake.
  - DONE -> IDLE (always, 1 cycle).
- busy = 1 in every state except IDLE.
- halt_req = 1 from HALT_WAIT through CSUM inclusive, and 0 in DONE and IDLE.
- halt_ack dropping while halt_req = 1 is a CPU protocol violation. The block ignores it and does not recheck.
- HEADER:
  - tx_valid = 1, tx_data = HEADER.
  - idx is set to FIRST_REG and checksum is cleared on entry.
- LOAD:
  - rd_addr = idx.
  - rd_data is captured into the word register at the end of the cycle.
  - tx_valid = 0 in this state.
- SEND:
  - tx_valid = 1.
  - tx_data = word[31:24], [23:16], [15:8], [7:0] in order (big-endian).
  - The byte counter advances only on handshake.
  - On each handshake, checksum ^= the byte sent.
  - After the 4th byte handshake, idx increments (no wrap beyond LAST_REG) and the byte counter returns to 0.
- CSUM: tx_valid = 1, tx_data = XOR of all data bytes (header excluded).
- Stream rule: while tx_valid = 1 and tx_ready = 0, tx_data is held stable and tx_valid is not withdrawn.
- rd_addr holds the last value outside LOAD. It is reset to 0 on entering IDLE.
- start in DONE or any busy state is dropped, not queued.
- Output timing: all outputs are registered or pure decodes of the state register. There is no combinational path from tx_ready to tx_valid.
- Latency with tx_ready tied high and halt_ack returned one cycle after halt_req:
  - start to first header byte: 2 cycles.
  - Each register: 5 cycles.
  - Whole frame (default params): 1 + 75 + 1 + 1 = 78 cycles from header to done.
- Frame length = 2 + 4 * (LAST_REG - FIRST_REG + 1) bytes; 62 for the defaults.

Decomposition:
- Shared CPU package holds:
  - the state encoding constants (IDLE, HALT_WAIT, HEADER, LOAD, SEND, CSUM, DONE; 3-bit);
  - the frame constant DUMP_HEADER = 8'hA5.
- One natural sub-module: dump_byte_ser, a 32-bit to 4x8-bit serializer with valid/ready, byte counter and last-byte flag.
- The FSM, checksum and halt handshake stay in regbank_dump.

Test Plan:
- Register contents and expected frame:
  - Preload rN = 32'h0101_0101 * N, with tx_ready = 1 and halt_ack looped from halt_req after 1 cycle.
  - Pulse start. Expect frame A5, 01 01 01 01, 02 02 02 02, ..., 0F 0F 0F 0F.
  - Checksum = 0x00; busy high for 80 cycles; done pulses once.
- Backpressure: toggle tx_ready pseudo-randomly. Expect tx_data stable and tx_valid high during every stall, the identical byte sequence, and no lost or duplicated bytes.
- Late halt_ack: hold halt_ack = 0 for 20 cycles. Expect halt_req = 1, tx_valid = 0 and rd_addr = 0 throughout. Header appears 1 cycle after ack.
- start while busy: pulse start mid-frame and in DONE. Expect exactly one 62-byte frame.
- Reset mid-frame: assert reset during byte 3 of r7. Expect immediate halt_req = 0, tx_valid = 0, busy = 0 and no done. A fresh start then yields a complete, correct frame.
- Checksum: r1 = 32'hDEADBEEF, all others 0. Expect checksum byte DE^AD^BE^EF = 0x22.
